// File: rtl/mesh_credit_wormhole_node.sv
// -----------------------------------------------------------------------------
// mesh_credit_wormhole_node
//   Five-port 2D-mesh wormhole router node with credit-based flow control.
//   Every input owns a flit FIFO and an XY (column-first) route register.
//   Every output owns an allocator that locks the output to one input for a
//   whole packet, a credit counter that tracks free downstream slots, and a
//   registered flit stage.
//
//   Port index: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
//   Flit layout: [FLIT_W-1:FLIT_W-2] = id (01 HEAD, 00 BODY, 10 TAIL,
//   11 HEAD_TAIL), [FLIT_DATA_W-1:0] = payload. In a head flit the payload
//   starts with dest_row in the low bits, followed by dest_col.
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous active-high reset
//   in_chan_data_i   input flits, port p at [p*FLIT_W +: FLIT_W]
//   in_chan_vld_i    per-input flit write strobe
//   in_chan_crd_o    per-input credit-return pulse (a flit left the FIFO)
//   out_chan_data_o  registered output flits, port p at [p*FLIT_W +: FLIT_W]
//   out_chan_vld_o   registered output flit valid
//   out_chan_crd_i   per-output credit-return pulse from downstream
//   err_ovf_o        sticky per-input FIFO overflow flag
// -----------------------------------------------------------------------------
module mesh_credit_wormhole_node #(
   parameter int FLIT_DATA_W = 8,
   parameter int ROW_ADDR_W  = 2,
   parameter int COL_ADDR_W  = 2,
   parameter int ROW_CORD    = 1,
   parameter int COL_CORD    = 1,
   parameter int BUF_DEPTH_W = 2,
   parameter int CREDITS     = 4,
   parameter int ARB_TYPE    = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [5*(FLIT_DATA_W+2)-1:0]   in_chan_data_i,
   input  logic [4:0]                     in_chan_vld_i,
   output logic [4:0]                     in_chan_crd_o,
   output logic [5*(FLIT_DATA_W+2)-1:0]   out_chan_data_o,
   output logic [4:0]                     out_chan_vld_o,
   input  logic [4:0]                     out_chan_crd_i,
   output logic [4:0]                     err_ovf_o
);

   localparam int FLIT_W = FLIT_DATA_W + 2;
   localparam int NP     = 5;
   localparam int DEPTH  = 1 << BUF_DEPTH_W;
   localparam int CRD_W  = $clog2(CREDITS + 1);

   localparam logic [CRD_W-1:0]       CRD_MAX  = CRD_W'(CREDITS);
   localparam logic [BUF_DEPTH_W:0]   CNT_FULL = (BUF_DEPTH_W+1)'(DEPTH);
   localparam logic [ROW_ADDR_W-1:0]  MY_ROW   = ROW_ADDR_W'(ROW_CORD);
   localparam logic [COL_ADDR_W-1:0]  MY_COL   = COL_ADDR_W'(COL_CORD);

   typedef enum logic [2:0] {
      P_LOCAL = 3'd0,
      P_NORTH = 3'd1,
      P_EAST  = 3'd2,
      P_SOUTH = 3'd3,
      P_WEST  = 3'd4
   } port_e;

   // ---------------- state ----------------
   logic [FLIT_W-1:0]      fifo_mem_q [NP][DEPTH];
   logic [BUF_DEPTH_W-1:0] rd_ptr_q   [NP];
   logic [BUF_DEPTH_W-1:0] wr_ptr_q   [NP];
   logic [BUF_DEPTH_W:0]   cnt_q      [NP];
   logic [BUF_DEPTH_W:0]   cnt_d      [NP];
   logic [NP-1:0]          ovf_q;
   port_e                  route_q    [NP];

   logic [NP-1:0]          lock_vld_q, lock_vld_d;
   logic [2:0]             lock_own_q [NP];
   logic [2:0]             lock_own_d [NP];
   logic [2:0]             rr_ptr_q   [NP];
   logic [2:0]             rr_ptr_d   [NP];
   logic [CRD_W-1:0]       credit_q   [NP];
   logic [CRD_W-1:0]       credit_d   [NP];
   logic [NP-1:0]          out_vld_q;
   logic [FLIT_W-1:0]      out_data_q [NP];

   // ---------------- per-input combinational view ----------------
   logic [FLIT_W-1:0]      head       [NP];
   logic [ROW_ADDR_W-1:0]  dest_row   [NP];
   logic [COL_ADDR_W-1:0]  dest_col   [NP];
   port_e                  route_comb [NP];
   port_e                  route_eff  [NP];
   logic [NP-1:0]          not_empty, full, is_head, is_tail;
   logic [NP-1:0]          wr_ok, ovf_set, pop;

   // ---------------- per-output combinational view ----------------
   logic [NP-1:0]          req        [NP];
   logic [NP-1:0]          gnt_vld, xfer;
   logic [2:0]             gnt_idx    [NP];
   logic [2:0]             own        [NP];

   // FIFO head decode and XY route. Body/tail flits follow the route latched
   // when their packet's head flit left the FIFO.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         head[i]      = fifo_mem_q[i][rd_ptr_q[i]];
         not_empty[i] = (cnt_q[i] != '0);
         full[i]      = (cnt_q[i] == CNT_FULL);
         is_head[i]   = head[i][FLIT_W-2];   // 01 or 11
         is_tail[i]   = head[i][FLIT_W-1];   // 10 or 11
         dest_row[i]  = head[i][ROW_ADDR_W-1:0];
         dest_col[i]  = head[i][ROW_ADDR_W +: COL_ADDR_W];
         if (dest_col[i] > MY_COL)      route_comb[i] = P_EAST;
         else if (dest_col[i] < MY_COL) route_comb[i] = P_WEST;
         else if (dest_row[i] > MY_ROW) route_comb[i] = P_SOUTH;
         else if (dest_row[i] < MY_ROW) route_comb[i] = P_NORTH;
         else                           route_comb[i] = P_LOCAL;
         route_eff[i] = is_head[i] ? route_comb[i] : route_q[i];
      end
   end

   // Allocation and transfer per output. A locked output serves only its
   // owner; an unlocked one grants among head flits routed to it. With
   // ARB_TYPE 0 the search always starts at input 0 (static priority).
   always_comb begin
      int start;
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves one unassigned would infer a latch.
      start = 0;
      for (int o = 0; o < NP; o++) begin
         gnt_vld[o] = 1'b0;
         gnt_idx[o] = '0;
         for (int i = 0; i < NP; i++)
            req[o][i] = not_empty[i] && is_head[i] && (route_comb[i] == port_e'(o));
         start = (ARB_TYPE == 1) ? int'(rr_ptr_q[o]) : 0;
         if (!lock_vld_q[o]) begin
            for (int k = 0; k < NP; k++) begin
               if (!gnt_vld[o] && req[o][(start + k) % NP]) begin
                  gnt_vld[o] = 1'b1;
                  gnt_idx[o] = 3'((start + k) % NP);
               end
            end
         end
         own[o]  = lock_vld_q[o] ? lock_own_q[o] : gnt_idx[o];
         xfer[o] = (lock_vld_q[o] || gnt_vld[o]) && not_empty[own[o]] &&
                   (route_eff[own[o]] == port_e'(o)) && (credit_q[o] != '0);
      end
   end

   // Input side: pop, write acceptance, overflow, occupancy.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         pop[i] = 1'b0;
         for (int o = 0; o < NP; o++)
            if (xfer[o] && (own[o] == 3'(i))) pop[i] = 1'b1;
         // A same-cycle pop frees a slot, so a write into a full FIFO is legal.
         wr_ok[i]   = in_chan_vld_i[i] && (!full[i] || pop[i]);
         ovf_set[i] = in_chan_vld_i[i] && full[i] && !pop[i];
         case ({wr_ok[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
            2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // Output side: lock, round-robin pointer and credit next state.
   always_comb begin
      for (int o = 0; o < NP; o++) begin
         lock_vld_d[o] = lock_vld_q[o];
         lock_own_d[o] = lock_own_q[o];
         rr_ptr_d[o]   = rr_ptr_q[o];
         credit_d[o]   = credit_q[o];
         if (gnt_vld[o]) begin
            lock_vld_d[o] = 1'b1;
            lock_own_d[o] = gnt_idx[o];
            rr_ptr_d[o]   = (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
         end
         // Tail leaving wins over a same-cycle grant (HEAD_TAIL case).
         if (xfer[o] && is_tail[own[o]]) lock_vld_d[o] = 1'b0;
         // Simultaneous spend and return cancel; returns beyond CREDITS are dropped.
         if (xfer[o] && !out_chan_crd_i[o])
            credit_d[o] = credit_q[o] - CRD_W'(1);
         else if (!xfer[o] && out_chan_crd_i[o] && (credit_q[o] != CRD_MAX))
            credit_d[o] = credit_q[o] + CRD_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NP; i++) begin
            rd_ptr_q[i]   <= '0;
            wr_ptr_q[i]   <= '0;
            cnt_q[i]      <= '0;
            route_q[i]    <= P_LOCAL;
            lock_own_q[i] <= '0;
            rr_ptr_q[i]   <= '0;
            credit_q[i]   <= CRD_MAX;
            out_data_q[i] <= '0;
         end
         ovf_q      <= '0;
         lock_vld_q <= '0;
         out_vld_q  <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (wr_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            cnt_q[i] <= cnt_d[i];
            if (pop[i] && is_head[i]) route_q[i] <= route_comb[i];
         end
         ovf_q <= ovf_q | ovf_set;
         for (int o = 0; o < NP; o++) begin
            lock_own_q[o] <= lock_own_d[o];
            rr_ptr_q[o]   <= rr_ptr_d[o];
            credit_q[o]   <= credit_d[o];
            if (xfer[o]) out_data_q[o] <= head[own[o]];
         end
         lock_vld_q <= lock_vld_d;
         out_vld_q  <= xfer;
      end
   end

   // NOTE: FIFO storage has no reset; emptiness comes from the reset pointers
   // and count, so stale entries are never read.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NP; i++)
         if (wr_ok[i]) fifo_mem_q[i][wr_ptr_q[i]] <= in_chan_data_i[i*FLIT_W +: FLIT_W];
   end

   for (genvar o = 0; o < NP; o++) begin : g_out
      assign out_chan_data_o[o*FLIT_W +: FLIT_W] = out_data_q[o];
   end

   assign out_chan_vld_o = out_vld_q;
   assign in_chan_crd_o  = pop;
   assign err_ovf_o      = ovf_q;

endmodule

// File: tb/tb_mesh_credit_wormhole_node.sv
// -----------------------------------------------------------------------------
// tb_mesh_credit_wormhole_node
//   Directed bench for the node at (row 1, col 1), CREDITS=4, depth 4,
//   round-robin allocation. Stimulus pushes expected flits into one queue per
//   output; a monitor on the falling edge pops and compares whenever an output
//   is valid. A simple downstream model returns one credit per received flit
//   on outputs where auto-return is enabled.
// -----------------------------------------------------------------------------
module tb_mesh_credit_wormhole_node;

   localparam int FW = 10;
   localparam int NP = 5;

   localparam logic [1:0] ID_HEAD = 2'b01;
   localparam logic [1:0] ID_BODY = 2'b00;
   localparam logic [1:0] ID_TAIL = 2'b10;
   localparam logic [1:0] ID_HT   = 2'b11;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [5*FW-1:0]   in_chan_data_i = '0;
   logic [4:0]        in_chan_vld_i  = '0;
   logic [4:0]        in_chan_crd_o;
   logic [5*FW-1:0]   out_chan_data_o;
   logic [4:0]        out_chan_vld_o;
   logic [4:0]        out_chan_crd_i;
   logic [4:0]        err_ovf_o;

   logic [4:0]        auto_en    = 5'b11111;
   logic [4:0]        auto_pulse = '0;
   logic [4:0]        man_crd    = '0;

   assign out_chan_crd_i = auto_pulse | man_crd;

   int checks = 0;
   int errors = 0;
   int out_cnt [NP];
   logic [FW-1:0] exp_q [NP][$];

   mesh_credit_wormhole_node #(
      .FLIT_DATA_W(8), .ROW_ADDR_W(2), .COL_ADDR_W(2),
      .ROW_CORD(1), .COL_CORD(1), .BUF_DEPTH_W(2),
      .CREDITS(4), .ARB_TYPE(1)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .in_chan_data_i (in_chan_data_i),
      .in_chan_vld_i  (in_chan_vld_i),
      .in_chan_crd_o  (in_chan_crd_o),
      .out_chan_data_o(out_chan_data_o),
      .out_chan_vld_o (out_chan_vld_o),
      .out_chan_crd_i (out_chan_crd_i),
      .err_ovf_o      (err_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Flit builder: {id, payload tag, dest_col, dest_row}.
   function automatic logic [FW-1:0] mk(input logic [1:0] id, input logic [3:0] tag,
                                        input logic [1:0] row, input logic [1:0] col);
      return {id, tag, col, row};
   endfunction

   task automatic put(input int p, input logic [FW-1:0] f);
      in_chan_data_i[p*FW +: FW] = f;
      in_chan_vld_i[p] = 1'b1;
   endtask

   task automatic put_exp(input int p, input int o, input logic [FW-1:0] f);
      put(p, f);
      exp_q[o].push_back(f);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      in_chan_vld_i = '0;
      man_crd = '0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic give_credit(input int o, input int n);
      repeat (n) begin
         man_crd[o] = 1'b1;
         tick();
      end
   endtask

   // Monitor / scoreboard and downstream credit model.
   initial begin
      logic [FW-1:0] e;
      for (int o = 0; o < NP; o++) out_cnt[o] = 0;
      forever begin
         @(negedge clk_i);
         for (int o = 0; o < NP; o++) begin
            auto_pulse[o] = auto_en[o] & out_chan_vld_o[o];
            if (out_chan_vld_o[o]) begin
               out_cnt[o]++;
               if (exp_q[o].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out%0d_unexpected: got flit 0x%0h, expected none",
                           o, out_chan_data_o[o*FW +: FW]);
               end else begin
                  e = exp_q[o].pop_front();
                  check($sformatf("out%0d_data", o), 64'(out_chan_data_o[o*FW +: FW]), 64'(e));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      logic [FW-1:0] f [4];

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_vld",  64'(out_chan_vld_o), 64'd0);
      check("rst_crd",  64'(in_chan_crd_o),  64'd0);
      check("rst_ovf",  64'(err_ovf_o),      64'd0);
      check("rst_data", 64'(|out_chan_data_o), 64'd0);
      rst_i = 1'b0;
      tick();

      // ---------------- single HEAD_TAIL, input 0 -> EAST ----------------
      put_exp(0, 2, mk(ID_HT, 4'hA, 2'd1, 2'd3));
      tick();
      check("t1_in_crd_t1", 64'(in_chan_crd_o), 64'b00001);
      check("t1_vld_t1",    64'(out_chan_vld_o), 64'd0);
      tick();
      check("t1_vld_t2",    64'(out_chan_vld_o), 64'b00100);
      tick();
      check("t1_vld_t3",    64'(out_chan_vld_o), 64'd0);
      ticks(3);

      // ---------------- 4-flit packet input 4 -> NORTH, no returns ----------------
      auto_en[1] = 1'b0;
      f[0] = mk(ID_HEAD, 4'h1, 2'd0, 2'd1);
      f[1] = mk(ID_BODY, 4'h2, 2'd0, 2'd1);
      f[2] = mk(ID_BODY, 4'h3, 2'd0, 2'd1);
      f[3] = mk(ID_TAIL, 4'h4, 2'd0, 2'd1);
      for (int k = 0; k < 4; k++) begin
         put_exp(4, 1, f[k]);
         tick();
         if (k >= 1) check($sformatf("t2_stream%0d", k), 64'(out_chan_vld_o[1]), 64'd1);
      end
      tick();
      check("t2_stream_tail", 64'(out_chan_vld_o[1]), 64'd1);
      tick();
      check("t2_after_tail",  64'(out_chan_vld_o[1]), 64'd0);
      // Next packet has no credit and must wait for one return.
      put_exp(4, 1, mk(ID_HT, 4'h5, 2'd0, 2'd1));
      tick();
      ticks(3);
      check("t2_stall_vld", 64'(out_chan_vld_o[1]), 64'd0);
      check("t2_stall_crd", 64'(in_chan_crd_o[4]),  64'd0);
      give_credit(1, 1);
      check("t2_resume_crd", 64'(in_chan_crd_o[4]),  64'd1);
      tick();
      check("t2_resume_vld", 64'(out_chan_vld_o[1]), 64'd1);
      // Over-return saturates at 4: only four of five flits may pass.
      give_credit(1, 6);
      c0 = out_cnt[1];
      for (int k = 0; k < 5; k++) begin
         put_exp(4, 1, mk(ID_HT, 4'(6 + k), 2'd0, 2'd1));
         tick();
      end
      ticks(6);
      check("t2_saturate", 64'(out_cnt[1] - c0), 64'd4);
      give_credit(1, 1);
      ticks(3);
      check("t2_last_out", 64'(out_cnt[1] - c0), 64'd5);
      give_credit(1, 4);
      auto_en[1] = 1'b1;
      ticks(2);

      // ---------------- round robin to LOCAL: inputs 1, 3, 4 ----------------
      for (int r = 0; r < 2; r++) begin
         c0 = out_cnt[0];
         put(1, mk(ID_HEAD, 4'(r), 2'd1, 2'd1));
         put(3, mk(ID_HEAD, 4'(r + 2), 2'd1, 2'd1));
         put(4, mk(ID_HEAD, 4'(r + 4), 2'd1, 2'd1));
         tick();
         put(1, mk(ID_TAIL, 4'(r + 8), 2'd1, 2'd1));
         put(3, mk(ID_TAIL, 4'(r + 10), 2'd1, 2'd1));
         put(4, mk(ID_TAIL, 4'(r + 12), 2'd1, 2'd1));
         tick();
         exp_q[0].push_back(mk(ID_HEAD, 4'(r),      2'd1, 2'd1));
         exp_q[0].push_back(mk(ID_TAIL, 4'(r + 8),  2'd1, 2'd1));
         exp_q[0].push_back(mk(ID_HEAD, 4'(r + 2),  2'd1, 2'd1));
         exp_q[0].push_back(mk(ID_TAIL, 4'(r + 10), 2'd1, 2'd1));
         exp_q[0].push_back(mk(ID_HEAD, 4'(r + 4),  2'd1, 2'd1));
         exp_q[0].push_back(mk(ID_TAIL, 4'(r + 12), 2'd1, 2'd1));
         ticks(10);
         check($sformatf("t3_round%0d_count", r), 64'(out_cnt[0] - c0), 64'd6);
      end

      // ---------------- parallel paths: 0 -> EAST, 2 -> WEST ----------------
      put_exp(0, 2, mk(ID_HT, 4'h6, 2'd1, 2'd3));
      put_exp(2, 4, mk(ID_HT, 4'h7, 2'd1, 2'd0));
      tick();
      tick();
      check("t4_parallel_vld", 64'(out_chan_vld_o), 64'b10100);
      ticks(4);

      // ---------------- overflow on input 3 while EAST has no credit ----------------
      auto_en[2] = 1'b0;
      ticks(2);
      for (int k = 0; k < 4; k++) begin
         put_exp(0, 2, mk(ID_HT, 4'(8 + k), 2'd1, 2'd3));
         tick();
      end
      ticks(4);
      c0 = out_cnt[2];
      for (int k = 0; k < 5; k++) begin
         if (k < 4) put_exp(3, 2, mk(ID_HT, 4'(k), 2'd1, 2'd3));
         else       put(3, mk(ID_HT, 4'hF, 2'd1, 2'd3));
         tick();
      end
      ticks(2);
      check("t5_ovf",     64'(err_ovf_o), 64'b01000);
      check("t5_blocked", 64'(out_cnt[2] - c0), 64'd0);
      give_credit(2, 4);
      ticks(4);
      check("t5_delivered",  64'(out_cnt[2] - c0), 64'd4);
      check("t5_ovf_sticky", 64'(err_ovf_o), 64'b01000);
      give_credit(2, 4);
      ticks(2);

      // ---------------- reset mid-packet ----------------
      put_exp(0, 2, mk(ID_HEAD, 4'h9, 2'd1, 2'd3));
      tick();
      put_exp(0, 2, mk(ID_BODY, 4'hA, 2'd1, 2'd3));
      tick();
      ticks(2);
      rst_i = 1'b1;
      #1;
      check("t6_rst_vld",  64'(out_chan_vld_o), 64'd0);
      check("t6_rst_data", 64'(|out_chan_data_o), 64'd0);
      check("t6_rst_crd",  64'(in_chan_crd_o), 64'd0);
      check("t6_rst_ovf",  64'(err_ovf_o), 64'd0);
      tick();
      rst_i = 1'b0;
      tick();
      // Fresh credits (4) and no stale lock: four flits from another input pass.
      c0 = out_cnt[2];
      for (int k = 0; k < 4; k++) begin
         put_exp(2, 2, mk(ID_HT, 4'(k + 3), 2'd1, 2'd3));
         tick();
         if (k == 1) check("t6_first_out", 64'(out_chan_vld_o[2]), 64'd1);
      end
      ticks(6);
      check("t6_count", 64'(out_cnt[2] - c0), 64'd4);

      // ---------------- drain check ----------------
      for (int o = 0; o < NP; o++)
         check($sformatf("exp_q%0d_empty", o), 64'(exp_q[o].size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
